// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, fetch FSM states and
// the PC helper used by the instruction-fetch front end.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    // Instructions are word aligned, so the two low address bits are forced to zero
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer that parks an instruction (and its PC) returned by
// instruction memory while decode is stalled. Clear beats load beats unload.
import mips_pkg::*;

module fetch_skid_buffer (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;

    // Next-entry selection: a flush empties the entry, a capture fills it, a drain empties it
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = INSTR_NOP;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage, emptied by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_NOP;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake,
// drives the IF/ID register and absorbs stalls and redirects.
// Optional macro FETCH_PERF_CNT_EN adds stall_cycles / flush_count counters.
import mips_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0]  pc_q,         pc_d;
    logic [ADDR_W-1:0]  drop_addr_q,  drop_addr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q,    ifid_pc_d;
    logic [ADDR_W-1:0]  ifid_pc4_q,   ifid_pc4_d;

    logic               ack_fire;
    logic               skid_load;
    logic               skid_unload;
    logic               skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // An ack only counts while a request is actually outstanding
    assign ack_fire = imem_req & imem_ack;

    // Fetch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next-state: redirect first, then stall/ack handling
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    state_d = ack_fire ? FETCH : DROP;
                end else if (ack_fire && stall) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (ack_fire) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs decoded from state and registers only; DROP keeps presenting the stale address
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // PC, IF/ID and skid control: redirect flushes everything, otherwise advance on ack or drain the skid
    always_comb begin
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        if (redirect) begin
            pc_d         = align_pc(redirect_pc);
            ifid_valid_d = 1'b0;
            ifid_instr_d = INSTR_NOP;
            skid_clear   = 1'b1;
            if (state_q == FETCH && !ack_fire) begin
                drop_addr_d = pc_q;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack_fire) begin
                        pc_d = pc_q + PC_STEP;
                        if (stall) begin
                            skid_load = 1'b1;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = imem_rdata;
                            ifid_pc_d    = pc_q;
                            ifid_pc4_d   = pc_q + PC_STEP;
                        end
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = INSTR_NOP;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid_d = skid_valid;
                        ifid_instr_d = skid_valid ? skid_instr : INSTR_NOP;
                        ifid_pc_d    = skid_pc;
                        ifid_pc4_d   = skid_pc + PC_STEP;
                        skid_unload  = 1'b1;
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    // PC, stale-request address and IF/ID pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= INSTR_NOP;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign pc_out     = pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q,  flush_count_d;

    // Count cycles where a live instruction is held by a stall, and every redirect
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && ifid_valid_q) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (redirect) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Performance counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a latency-programmable imem model
// and a queue of expected IF/ID contents.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_lat;
    int   wait_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory contents: fixed word at 0, address-derived pattern elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory model: ack after mem_lat waiting cycles of an outstanding request
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus-only helper: reset with quiet inputs, returns at the negedge rst drops
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        mem_lat = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] a4);
        exp_t e;
        e.instr = mem_word(a);
        e.pc    = a;
        e.pc4   = a4;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        mem_lat = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({pc_out, imem_req, imem_addr} !== {32'h0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("[TB] FAIL reset_pc_req: got %h want %h", {pc_out, imem_req, imem_addr}, {32'h0, 1'b0, 32'h0});
        end
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== 97'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, 97'h0);
        end
    endtask

    task automatic test_first_fetch();
        exp_t e;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL first_req: got %h want %h", {imem_req, imem_addr, ifid_valid}, {1'b1, 32'h0, 1'b0});
        end
        push_exp(32'h0, 32'h4);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
            n_bad++;
            $display("[TB] FAIL first_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
        end
        n_cmp++;
        if (pc_out !== 32'h4) begin
            n_bad++;
            $display("[TB] FAIL first_pc_out: got %h want %h", pc_out, 32'h4);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] a;
        for (int k = 1; k <= 3; k++) begin
            a = 32'(4 * k);
            push_exp(a, a + 32'h4);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
                n_bad++;
                $display("[TB] FAIL b2b_ifid_%0d: got %h want %h", k, {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
            end
        end
        n_cmp++;
        if (pc_out !== 32'h10) begin
            n_bad++;
            $display("[TB] FAIL b2b_pc_out: got %h want %h", pc_out, 32'h10);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        exp_t held;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        push_exp(32'h4, 32'h8);
        @(negedge clk);
        held = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, held}) begin
            n_bad++;
            $display("[TB] FAIL stall_pre_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, held});
        end
        push_exp(32'h8, 32'hC);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4, imem_req, pc_out} !== {1'b1, held, 1'b0, 32'hC}) begin
                n_bad++;
                $display("[TB] FAIL stall_hold_%0d: got %h want %h", i,
                         {ifid_valid, ifid_instr, ifid_pc, ifid_pc4, imem_req, pc_out}, {1'b1, held, 1'b0, 32'hC});
            end
        end
        stall = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
            n_bad++;
            $display("[TB] FAIL stall_skid_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
        end
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
            n_bad++;
            $display("[TB] FAIL stall_resume_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'hC});
        end
        push_exp(32'hC, 32'h10);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
            n_bad++;
            $display("[TB] FAIL stall_after_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd3) begin
            n_bad++;
            $display("[TB] FAIL perf_stall_cycles: got %0d want %0d", stall_cycles, 3);
        end
`endif
    endtask

    task automatic test_drop();
        exp_t e;
        do_reset();
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({imem_addr, ifid_valid, ifid_pc} !== {32'h10, 1'b1, 32'hC}) begin
            n_bad++;
            $display("[TB] FAIL drop_setup: got %h want %h", {imem_addr, ifid_valid, ifid_pc}, {32'h10, 1'b1, 32'hC});
        end
        mem_lat = 2;
        @(negedge clk);
        n_cmp++;
        if ({imem_req, imem_addr, imem_ack, ifid_valid} !== {1'b1, 32'h10, 1'b0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL drop_wait: got %h want %h", {imem_req, imem_addr, imem_ack, ifid_valid}, {1'b1, 32'h10, 1'b0, 1'b0});
        end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++;
        if ({imem_req, imem_addr, pc_out, ifid_valid, ifid_instr} !== {1'b1, 32'h10, 32'h40, 1'b0, 32'h0}) begin
            n_bad++;
            $display("[TB] FAIL drop_state: got %h want %h",
                     {imem_req, imem_addr, pc_out, ifid_valid, ifid_instr}, {1'b1, 32'h10, 32'h40, 1'b0, 32'h0});
        end
        @(negedge clk);
        n_cmp++;
        if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h40, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL drop_retarget: got %h want %h", {imem_req, imem_addr, ifid_valid}, {1'b1, 32'h40, 1'b0});
        end
        mem_lat = 0;
        push_exp(32'h40, 32'h44);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
            n_bad++;
            $display("[TB] FAIL drop_target_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
        end
    endtask

    task automatic test_redirect_stall();
        exp_t e;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        n_cmp++;
        if ({ifid_valid, ifid_instr, pc_out, imem_addr} !== {1'b0, 32'h0, 32'h100, 32'h100}) begin
            n_bad++;
            $display("[TB] FAIL redir_stall: got %h want %h", {ifid_valid, ifid_instr, pc_out, imem_addr}, {1'b0, 32'h0, 32'h100, 32'h100});
        end
        push_exp(32'h100, 32'h104);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
            n_bad++;
            $display("[TB] FAIL redir_target_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("[TB] FAIL wrap_addr: got %h want %h", imem_addr, 32'hFFFF_FFFC);
        end
        push_exp(32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4, pc_out} !== {1'b1, e, 32'h0}) begin
            n_bad++;
            $display("[TB] FAIL wrap_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4, pc_out}, {1'b1, e, 32'h0});
        end
    endtask

    task automatic test_async_reset_hold();
        exp_t e;
        stall = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL arst_in_hold: got %b want %b", imem_req, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({pc_out, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {32'h0, 1'b0, 32'h0, 97'h0}) begin
            n_bad++;
            $display("[TB] FAIL arst_immediate: got %h want %h",
                     {pc_out, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {32'h0, 1'b0, 32'h0, 97'h0});
        end
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("[TB] FAIL arst_restart_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
        push_exp(32'h0, 32'h4);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc4} !== {1'b1, e}) begin
            n_bad++;
            $display("[TB] FAIL arst_restart_ifid: got %h want %h", {ifid_valid, ifid_instr, ifid_pc, ifid_pc4}, {1'b1, e});
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_stall();
        test_drop();
        test_redirect_stall();
        test_wrap();
        test_async_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
